// File: rtl/hazard_detect_pkg.sv
// Shared opcode, hazard-code and shadow-entry definitions for the ID-stage hazard detector.
package hazard_detect_pkg;

  localparam int unsigned OP_W  = 7;
  localparam int unsigned REG_W = 5;
  localparam int unsigned HZ_W  = 3;

  localparam logic [OP_W-1:0] LOAD   = 7'b0000011;
  localparam logic [OP_W-1:0] STORE  = 7'b0100011;
  localparam logic [OP_W-1:0] BRANCH = 7'b1100011;
  localparam logic [OP_W-1:0] OP     = 7'b0110011;
  localparam logic [OP_W-1:0] OP_IMM = 7'b0010011;
  localparam logic [OP_W-1:0] JAL    = 7'b1101111;
  localparam logic [OP_W-1:0] JALR   = 7'b1100111;
  localparam logic [OP_W-1:0] LUI    = 7'b0110111;
  localparam logic [OP_W-1:0] AUIPC  = 7'b0010111;

  localparam logic [HZ_W-1:0] HZ_NONE     = 3'd0;
  localparam logic [HZ_W-1:0] HZ_EX_RS1   = 3'd1;
  localparam logic [HZ_W-1:0] HZ_EX_RS2   = 3'd2;
  localparam logic [HZ_W-1:0] HZ_MEM_RS1  = 3'd3;
  localparam logic [HZ_W-1:0] HZ_MEM_RS2  = 3'd4;
  localparam logic [HZ_W-1:0] HZ_EX_BOTH  = 3'd5;
  localparam logic [HZ_W-1:0] HZ_MEM_BOTH = 3'd6;

  // One in-flight destination shadow (EX or MEM slot)
  typedef struct packed {
    logic             vld;
    logic [REG_W-1:0] rd;
    logic [OP_W-1:0]  op;
  } stage_entry_t;

  // Ops whose result only exists on the MEM path (load data, link value)
  function automatic logic late_result(input logic [OP_W-1:0] op);
    return (op == LOAD) || (op == JAL) || (op == JALR);
  endfunction

  function automatic logic [HZ_W-1:0] hz_code(input logic m1, input logic m2,
                                               input logic [HZ_W-1:0] c1,
                                               input logic [HZ_W-1:0] c2,
                                               input logic [HZ_W-1:0] cboth);
    if (m1 && m2) return cboth;
    if (m1)       return c1;
    if (m2)       return c2;
    return HZ_NONE;
  endfunction

endpackage

// File: rtl/hazard_detect_src_use_decode.sv
// Opcode decode of which register fields an RV32I instruction reads and writes.
module src_use_decode
  import hazard_detect_pkg::*;
(
  input  logic [OP_W-1:0] op,
  output logic            uses_rs1,
  output logic            uses_rs2,
  output logic            writes_rd
);

  always_comb begin
    uses_rs1  = 1'b1;
    uses_rs2  = 1'b0;
    writes_rd = 1'b1;
    case (op)
      LUI, AUIPC, JAL: uses_rs1 = 1'b0;
      OP:              uses_rs2 = 1'b1;
      STORE, BRANCH: begin
        uses_rs2  = 1'b1;
        writes_rd = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/hazard_detect.sv
// ID-stage hazard detector: EX/MEM destination shadow, forwarding codes and load/link stall.
module hazard_detect
  import hazard_detect_pkg::*;
#(
  parameter int unsigned STALL_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   id_valid,
  input  logic [OP_W-1:0]        id_op,
  input  logic [REG_W-1:0]       id_rs1,
  input  logic [REG_W-1:0]       id_rs2,
  input  logic [REG_W-1:0]       id_rd,
  input  logic                   flush,
  output logic                   is_hazard1,
  output logic [HZ_W-1:0]        hazard_reg1,
  output logic                   is_hazard2,
  output logic [HZ_W-1:0]        hazard_reg2,
  output logic [OP_W-1:0]        mem_op,
  output logic                   stall,
  output logic [STALL_CNT_W-1:0] stall_count
);

  stage_entry_t ex_q, mem_q;

  logic id_uses_rs1, id_uses_rs2, id_writes_unused;
  logic ex_writes, ex_rs1_unused, ex_rs2_unused;
  logic mem_writes, mem_rs1_unused, mem_rs2_unused;

  src_use_decode u_id_dec (
    .op        (id_op),
    .uses_rs1  (id_uses_rs1),
    .uses_rs2  (id_uses_rs2),
    .writes_rd (id_writes_unused)
  );

  src_use_decode u_ex_dec (
    .op        (ex_q.op),
    .uses_rs1  (ex_rs1_unused),
    .uses_rs2  (ex_rs2_unused),
    .writes_rd (ex_writes)
  );

  src_use_decode u_mem_dec (
    .op        (mem_q.op),
    .uses_rs1  (mem_rs1_unused),
    .uses_rs2  (mem_rs2_unused),
    .writes_rd (mem_writes)
  );

  logic ex_wr, mem_wr;
  logic match_ex_rs1, match_ex_rs2, match_mem_rs1, match_mem_rs2;

  // x0 never matches because a zero rd never qualifies as a write
  always_comb begin
    ex_wr  = ex_q.vld  && (ex_q.rd  != '0) && ex_writes;
    mem_wr = mem_q.vld && (mem_q.rd != '0) && mem_writes;

    match_ex_rs1  = id_valid && id_uses_rs1 && ex_wr && (ex_q.rd == id_rs1);
    match_ex_rs2  = id_valid && id_uses_rs2 && ex_wr && (ex_q.rd == id_rs2);
    match_mem_rs1 = id_valid && id_uses_rs1 && mem_wr && (mem_q.rd == id_rs1) && !match_ex_rs1;
    match_mem_rs2 = id_valid && id_uses_rs2 && mem_wr && (mem_q.rd == id_rs2) && !match_ex_rs2;

    hazard_reg1 = hz_code(match_ex_rs1, match_ex_rs2, HZ_EX_RS1, HZ_EX_RS2, HZ_EX_BOTH);
    hazard_reg2 = hz_code(match_mem_rs1, match_mem_rs2, HZ_MEM_RS1, HZ_MEM_RS2, HZ_MEM_BOTH);
    is_hazard1  = (hazard_reg1 != HZ_NONE);
    is_hazard2  = (hazard_reg2 != HZ_NONE);

    stall = !flush && (match_ex_rs1 || match_ex_rs2) && late_result(ex_q.op);
  end

  assign mem_op = mem_q.op;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q        <= '0;
      mem_q       <= '0;
      stall_count <= '0;
    end else begin
      mem_q <= ex_q;
      if (flush || stall) begin
        ex_q <= '0;
      end else begin
        ex_q <= '{vld: id_valid, rd: id_rd, op: id_op};
      end
      if (stall && (stall_count != {STALL_CNT_W{1'b1}})) begin
        stall_count <= stall_count + STALL_CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/hazard_detect.md
Name: hazard_detect

Overview:
- Sits in the ID stage of the 5-stage RV32I pipeline, directly upstream of the forwarding unit.
- Keeps its own two-entry shadow of the destination registers in flight in EX and MEM.
- Compares them against the decoding instruction's sources and produces the forwarding unit's inputs: is_hazard1/2, hazard_reg1/2 and the MEM-stage op.
- Raises a one-cycle stall when forwarding cannot cover the dependency, and counts stall cycles.

Parameters:
- STALL_CNT_W, 32, width of the stall-cycle performance counter.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  reset; synchronous, active-high
- id_valid  in  1  ID holds a real instruction
- id_op  in  7  ID opcode
- id_rs1  in  5  ID source register 1
- id_rs2  in  5  ID source register 2
- id_rd  in  5  ID destination register
- flush  in  1  taken branch/jump resolved in EX; squash ID
- is_hazard1  out  1  EX-stage match exists
- hazard_reg1  out  3  0 none, 1 rs1 from EX, 2 rs2 from EX, 5 both from EX
- is_hazard2  out  1  MEM-stage match exists
- hazard_reg2  out  3  0 none, 3 rs1 from MEM, 4 rs2 from MEM, 6 both from MEM
- mem_op  out  7  opcode of the MEM-stage entry (forwarding op input)
- stall  out  1  hold PC and IF/ID, insert bubble into ID/EX
- stall_count  out  STALL_CNT_W  stall cycles since reset, saturating

Behaviour:
- Shadow entries ex_{vld,rd,op} and mem_{vld,rd,op} are registered.
- Reset sets both entries invalid (rd=0, op=0) and stall_count=0.
- Combinational consequences of reset:
  - hazard outputs are 0;
  - mem_op is 0;
  - stall is 0.
- Entry writes rd only if vld and rd!=0 and op is not STORE or BRANCH.
- Source usage is decoded from id_op:
  - rs1 is used by all ops except LUI, AUIPC and JAL.
  - rs2 is used only by OP, STORE and BRANCH.
- Matching (combinational, same cycle as ID fields):
  - match_ex_rsN = id_valid & usesN & ex-writes & ex_rd==id_rsN.
  - match_mem_rsN is the same against mem_rd, excluding any rsN already matched in EX (EX wins, it is the younger value).
  - x0 never matches.
- Hazard outputs:
  - hazard_reg1 = 1 / 2 / 5 for rs1 only / rs2 only / both matched in EX; is_hazard1 = hazard_reg1!=0.
  - hazard_reg2 uses 3 / 4 / 6 likewise for MEM; is_hazard2 = hazard_reg2!=0.
  - Codes 5 and 6 are new; the forwarding unit gains cases for them in the same change.
- Stall condition, combinational:
  - stall = !flush & (any EX match) & ex_op is one of LOAD, JAL or JALR.
  - The load data and link value are only available on the MEM path.
- Advance at each clk edge, not in reset:
  - mem <= ex, always.
  - If flush or stall: ex <= invalid bubble.
  - Otherwise: ex <= {id_valid, id_rd, id_op}.
- Latency:
  - A dependency stalls exactly one cycle.
  - In the following cycle the producer is in MEM and the consumer reports hazard_reg2=3/4/6 with mem_op = LOAD, JAL or JALR.
- Simultaneous flush and stall: flush wins. stall=0, ex becomes a bubble, counter unchanged.
- stall_count increments on every cycle with stall=1 and saturates at all-ones.
- Reset mid-stall: next cycle stall=0 and both entries are invalid. The in-flight instruction is abandoned (the pipeline is reset too).
- Both hazards active on different registers (e.g. rs1 from EX, rs2 from MEM): codes are reported independently.

Decomposition:
- Shared package/header holds:
  - opcode constants (LOAD, STORE, BRANCH, OP, OP_IMM, JAL, JALR, LUI, AUIPC);
  - hazard code constants (HZ_NONE=0, HZ_EX_RS1=1, HZ_EX_RS2=2, HZ_MEM_RS1=3, HZ_MEM_RS2=4, HZ_EX_BOTH=5, HZ_MEM_BOTH=6).
- One natural sub-module, src_use_decode: op in, uses_rs1/uses_rs2/writes_rd out. It is reused by the entry-write qualification.

Test Plan:
- Back-to-back dependency: `add x5,x1,x2` then `sub x6,x5,x3`.
  - Cycle 2: is_hazard1=1, hazard_reg1=1, stall=0.
  - One cycle later a dependent in ID gives hazard_reg2=3, mem_op=OP.
- Load-use: `lw x7,0(x1)` then `add x8,x2,x7`.
  - stall=1 for exactly one cycle and stall_count=1.
  - Next cycle hazard_reg2=4 and mem_op=LOAD.
- Both sources from the same stage: `addi x4,..` then `add x9,x4,x4` gives hazard_reg1=5. The same pair with one unrelated instruction between gives hazard_reg2=6.
- Priority and x0:
  - `addi x3` (now in MEM), `addi x3` (now in EX), then `add x1,x3,x0` gives hazard_reg1=1, hazard_reg2=0.
  - `addi x0,..` followed by its consumer gives no hazard.
- Flush with a pending stall: load in EX, dependent in ID, flush=1.
  - stall=0 and stall_count unchanged.
  - Next cycle the EX entry is a bubble and there is no hazard.
- Reset during stall: assert rst in the stall cycle. Next cycle stall=0, all codes 0, mem_op=0, stall_count=0.
